// File: rtl/cm_link_pkg.sv
// rtl/cm_link_pkg.sv - shared constants and types for the complex-multiply output link
//
// Purpose: frame geometry, default header byte, FSM state type and the
// byte-select helper used by the output serializer.
package cm_link_pkg;

  localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
  localparam int         NUM_WORDS        = 6;
  localparam int         BYTES_PER_WORD   = 2;
  localparam int         DATA_BYTES       = NUM_WORDS * BYTES_PER_WORD;
  localparam int         FRAME_LEN_CSUM   = DATA_BYTES + 2;
  localparam int         FRAME_LEN_NOCSUM = DATA_BYTES + 1;
  localparam logic [3:0] LAST_DATA_IDX    = 4'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } cm_state_e;

  // Words are packed with out1_real in the low bits, so byte i of the
  // frame payload is simply bits [8*i +: 8] (LSB byte of each word first).
  function automatic logic [7:0] payload_byte(input logic [8*DATA_BYTES-1:0] words,
                                              input logic [3:0]              idx);
    return words[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cm_out_serializer.sv
// rtl/cm_out_serializer.sv - byte framer for the complex-multiply results
//
// Purpose: latches six 16-bit results on capture and streams
//   HEADER, 12 payload bytes (LSB first per word), optional XOR checksum
// over an 8-bit valid/ready port. All outputs are registered.
//
// Ports:
//   CLK, reset                 clock, asynchronous active-high reset
//   capture                    one-cycle strobe latching the six words
//   out{1,2,3}_{real,img}      16-bit results from the core
//   tx_data/tx_valid/tx_ready  byte stream towards the pins
//   busy                       frame in progress
//   frame_done                 pulse the cycle after the final accept
//   overrun / ovr_clr          sticky dropped-capture flag and its clear
module cm_out_serializer
  import cm_link_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEFAULT,
  parameter bit         CSUM_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        capture,
  input  logic [15:0] out1_real,
  input  logic [15:0] out1_img,
  input  logic [15:0] out2_real,
  input  logic [15:0] out2_img,
  input  logic [15:0] out3_real,
  input  logic [15:0] out3_img,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  input  logic        ovr_clr
);

  localparam int CAP_W = 8 * DATA_BYTES;

  cm_state_e        state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             frame_end;
  logic             cap_ok;
  logic [7:0]       acc_next;

  assign accept   = tx_valid_q & tx_ready;
  assign acc_next = acc_q ^ tx_data_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    cap_d        = cap_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    frame_end    = 1'b0;

    // The next byte is prepared in the accept cycle so tx_data stays a
    // pure register and holds untouched while the sink stalls.
    case (state_q)
      IDLE: ;
      HDR: begin
        if (accept) begin
          state_d   = DATA;
          idx_d     = 4'd0;
          acc_d     = 8'd0;
          tx_data_d = payload_byte(cap_q, 4'd0);
        end
      end
      DATA: begin
        if (accept) begin
          acc_d = acc_next;
          if (idx_q == LAST_DATA_IDX) begin
            if (CSUM_EN) begin
              state_d   = CSUM;
              tx_data_d = acc_next;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            idx_d     = 4'(idx_q + 4'd1);
            tx_data_d = payload_byte(cap_q, 4'(idx_q + 4'd1));
          end
        end
      end
      CSUM: begin
        if (accept) begin
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      frame_done_d = 1'b1;
      state_d      = IDLE;
      idx_d        = 4'd0;
      tx_data_d    = 8'd0;
      tx_valid_d   = 1'b0;
      busy_d       = 1'b0;
    end

    // A capture landing on the final accept starts the next frame with
    // no idle gap; anywhere else mid-frame it is dropped.
    cap_ok = capture & ((state_q == IDLE) | frame_end);
    if (cap_ok) begin
      state_d    = HDR;
      idx_d      = 4'd0;
      cap_d      = {out3_img, out3_real, out2_img, out2_real, out1_img, out1_real};
      tx_data_d  = HEADER;
      tx_valid_d = 1'b1;
      busy_d     = 1'b1;
    end

    // Set has priority over clear so a drop is never lost.
    if (ovr_clr) overrun_d = 1'b0;
    if (capture & ~cap_ok) overrun_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      acc_q        <= 8'd0;
      cap_q        <= '0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      cap_q        <= cap_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cm_out_serializer.sv
// tb/tb_cm_out_serializer.sv - self-checking bench for cm_out_serializer
module tb_cm_out_serializer;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        capture = 1'b0;
  logic        tx_ready = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] w [6];

  logic       cap0, cap1;
  logic [7:0] d0_data, d1_data, o_data;
  logic       d0_valid, d1_valid, o_valid;
  logic       d0_busy, d1_busy, o_busy;
  logic       d0_done, d1_done, o_done;
  logic       d0_ovr, d1_ovr, o_ovr;

  always #5 CLK = ~CLK;

  assign cap0 = capture & ~sel;
  assign cap1 = capture & sel;

  cm_out_serializer #(.HEADER(8'hA5), .CSUM_EN(1'b1)) dut (
    .CLK(CLK), .reset(reset), .capture(cap0),
    .out1_real(w[0]), .out1_img(w[1]), .out2_real(w[2]),
    .out2_img(w[3]), .out3_real(w[4]), .out3_img(w[5]),
    .tx_data(d0_data), .tx_valid(d0_valid), .tx_ready(tx_ready),
    .busy(d0_busy), .frame_done(d0_done), .overrun(d0_ovr), .ovr_clr(ovr_clr & ~sel)
  );

  cm_out_serializer #(.HEADER(8'hA5), .CSUM_EN(1'b0)) dut_nocs (
    .CLK(CLK), .reset(reset), .capture(cap1),
    .out1_real(w[0]), .out1_img(w[1]), .out2_real(w[2]),
    .out2_img(w[3]), .out3_real(w[4]), .out3_img(w[5]),
    .tx_data(d1_data), .tx_valid(d1_valid), .tx_ready(tx_ready),
    .busy(d1_busy), .frame_done(d1_done), .overrun(d1_ovr), .ovr_clr(ovr_clr & sel)
  );

  assign o_data  = sel ? d1_data  : d0_data;
  assign o_valid = sel ? d1_valid : d0_valid;
  assign o_busy  = sel ? d1_busy  : d0_busy;
  assign o_done  = sel ? d1_done  : d0_done;
  assign o_ovr   = sel ? d1_ovr   : d0_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected byte stream, bytes left in the current frame,
  // frame-in-progress flag and the sticky overrun flag.
  logic [7:0] q[$];
  logic [7:0] got_q[$];
  int         m_left = 0;
  bit         m_busy = 0;
  bit         e_ovr  = 0;

  task automatic push_frame();
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    q.push_back(8'hA5);
    for (int i = 0; i < 12; i++) begin
      b = (i % 2 == 1) ? w[i/2][15:8] : w[i/2][7:0];
      x = x ^ b;
      q.push_back(b);
    end
    if (!sel) q.push_back(x);
  endtask

  task automatic cycle();
    bit         acc, last, cap_ok, hold_chk, e_done;
    logic [7:0] hold, exp_b;
    acc  = o_valid && tx_ready;
    last = 0;
    if (acc) begin
      if (q.size() == 0) begin
        chk("stray_byte", 32'd1, 32'd0);
      end else begin
        exp_b = q.pop_front();
        chk("tx_data", {24'd0, o_data}, {24'd0, exp_b});
        got_q.push_back(o_data);
      end
      m_left--;
      last = (m_left == 0);
    end
    cap_ok = capture && (!m_busy || last);
    if (cap_ok) begin
      push_frame();
      m_left = sel ? 13 : 14;
    end
    if (capture && !cap_ok) e_ovr = 1;
    else if (ovr_clr) e_ovr = 0;
    e_done = acc && last;
    if (cap_ok) m_busy = 1;
    else if (acc && last) m_busy = 0;
    hold_chk = o_valid && !tx_ready;
    hold     = o_data;
    @(posedge CLK);
    #1;
    chk("frame_done", {31'd0, o_done}, {31'd0, e_done});
    chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
    chk("tx_valid", {31'd0, o_valid}, {31'd0, m_busy});
    chk("overrun", {31'd0, o_ovr}, {31'd0, e_ovr});
    if (hold_chk) chk("stall_hold", {24'd0, o_data}, {24'd0, hold});
  endtask

  task automatic run_idle(input int mode, input int max_cyc);
    int k;
    k = 0;
    while (m_busy && k < max_cyc) begin
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (k % 4 == 0) || (k % 4 == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      k++;
    end
    if (m_busy) chk("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_tx_data", {24'd0, o_data}, 32'd0);
    chk("rst_tx_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_frame_done", {31'd0, o_done}, 32'd0);
    chk("rst_overrun", {31'd0, o_ovr}, 32'd0);
    q.delete();
    m_left = 0;
    m_busy = 0;
    e_ovr  = 0;
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_single();
    for (int i = 0; i < 6; i++) w[i] = 16'h0000;
    w[0] = 16'h1234;
  endtask

  task automatic start_frame();
    capture = 1'b1;
    cycle();
    capture = 1'b0;
  endtask

  initial begin
    int k;
    set_single();
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Single frame with fixed expected bytes
    got_q.delete();
    tx_ready = 1'b1;
    start_frame();
    run_idle(0, 40);
    chk("single_len", got_q.size(), 32'd14);
    if (got_q.size() == 14) begin
      chk("single_hdr", {24'd0, got_q[0]}, 32'h A5);
      chk("single_b1", {24'd0, got_q[1]}, 32'h34);
      chk("single_b2", {24'd0, got_q[2]}, 32'h12);
      chk("single_csum", {24'd0, got_q[13]}, 32'h26);
    end
    cycle();

    // Backpressure 1,0,0,1
    got_q.delete();
    start_frame();
    run_idle(1, 100);
    chk("bp_len", got_q.size(), 32'd14);

    // Capture isolation
    start_frame();
    for (int i = 0; i < 6; i++) w[i] = 16'hFFFF;
    run_idle(2, 200);
    set_single();

    // Overrun at byte 5, then clear
    tx_ready = 1'b1;
    start_frame();
    repeat (5) cycle();
    capture = 1'b1;
    cycle();
    capture = 1'b0;
    chk("ovr_set", {31'd0, o_ovr}, 32'd1);
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
    chk("ovr_clr", {31'd0, o_ovr}, 32'd0);
    run_idle(0, 40);

    // Back-to-back capture in the final-accept cycle
    start_frame();
    k = 0;
    while (m_left != 1 && k < 40) begin
      cycle();
      k++;
    end
    for (int i = 0; i < 6; i++) w[i] = 16'h0000;
    w[5] = 16'hBEEF;
    got_q.delete();
    capture = 1'b1;
    cycle();
    capture = 1'b0;
    chk("b2b_hdr_no_gap", {24'd0, o_data}, 32'hA5);
    run_idle(0, 40);
    chk("b2b_len", got_q.size(), 32'd15);
    if (got_q.size() == 15) begin
      chk("b2b_ef", {24'd0, got_q[12]}, 32'hEF);
      chk("b2b_be", {24'd0, got_q[13]}, 32'hBE);
      chk("b2b_csum", {24'd0, got_q[14]}, 32'h51);
    end
    chk("b2b_no_ovr", {31'd0, o_ovr}, 32'd0);

    // Reset at byte 7, then a fresh frame
    set_single();
    start_frame();
    repeat (7) cycle();
    do_reset();
    got_q.delete();
    start_frame();
    run_idle(0, 40);
    if (got_q.size() > 0) chk("post_rst_hdr", {24'd0, got_q[0]}, 32'hA5);
    else chk("post_rst_hdr_missing", 32'd1, 32'd0);

    // CSUM_EN=0 single frame
    sel = 1'b1;
    #1;
    got_q.delete();
    start_frame();
    run_idle(0, 40);
    chk("nocs_len", got_q.size(), 32'd13);

    // Randomized traffic on both variants
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 15) == 0)
          for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        capture  = ($urandom_range(0, 9) == 0);
        ovr_clr  = ($urandom_range(0, 15) == 0);
        tx_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      capture = 1'b0;
      ovr_clr = 1'b0;
      run_idle(2, 300);
      chk("rand_queue_empty", q.size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
